// File: rtl/rob_pkg.sv
// Shared encodings and widths for the reorder buffer.
// Imported by the top and its lane-selection sub-module.
package rob_pkg;

   localparam int CLS_W = 3;
   localparam int RD_W  = 5;
   localparam int VAL_W = 32;

   typedef enum logic [CLS_W-1:0] {
      CLS_ALU    = 3'd0,
      CLS_LOAD   = 3'd1,
      CLS_STORE  = 3'd2,
      CLS_BRANCH = 3'd3,
      CLS_JUMP   = 3'd4,
      CLS_UPPER  = 3'd5
   } cls_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Retire-lane selection: in-order prefix of done entries, stopped by
// a store outside lane 0, after a store, or after a mispredicted branch.
module rob_commit_sel
   import rob_pkg::*;
#(
   parameter int COMMIT_W = 2,
   parameter int CNT_W    = clog2(COMMIT_W + 1),
   parameter int LANE_W   = (COMMIT_W > 1) ? clog2(COMMIT_W) : 1
) (
   input  logic                      en,
   input  logic [COMMIT_W-1:0]       busy,
   input  logic [COMMIT_W-1:0]       done,
   input  logic [COMMIT_W-1:0]       mispred,
   input  logic [COMMIT_W*CLS_W-1:0] cls,
   output logic [COMMIT_W-1:0]       valid,
   output logic [CNT_W-1:0]          n_ret,
   output logic                      flush,
   output logic [LANE_W-1:0]         flush_lane
);

   always_comb begin
      logic go;
      cls_e c;
      go         = en;
      c          = CLS_ALU;
      valid      = '0;
      n_ret      = '0;
      flush      = 1'b0;
      flush_lane = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         c = cls_e'(cls[k*CLS_W +: CLS_W]);
         if (go && busy[k] && done[k] && (k == 0 || c != CLS_STORE)) begin
            valid[k] = 1'b1;
            n_ret    = CNT_W'(k + 1);
            if (c == CLS_STORE) go = 1'b0;
            if (c == CLS_BRANCH && mispred[k]) begin
               flush      = 1'b1;
               flush_lane = LANE_W'(k);
               go         = 1'b0;
            end
         end else begin
            go = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with multi-lane in-order retire, writeback bypass on
// operand lookup and precise flush when a mispredicted branch retires.
module rob_multi_commit
   import rob_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int COMMIT_W = 2,
   parameter int NUM_WB   = 2,
   parameter int IDW      = clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       issue_valid,
   input  logic [CLS_W-1:0]           issue_cls,
   input  logic [RD_W-1:0]            issue_rd,
   input  logic [31:0]                issue_pc,
   input  logic [VAL_W-1:0]           issue_val,
   input  logic                       issue_done,
   output logic [IDW-1:0]             alloc_id,
   output logic                       full,
   output logic [IDW-1:0]             head_id,
   output logic [IDW:0]               count,
   input  logic [NUM_WB-1:0]          wb_valid,
   input  logic [NUM_WB*IDW-1:0]      wb_id,
   input  logic [NUM_WB*VAL_W-1:0]    wb_val,
   input  logic [NUM_WB-1:0]          wb_mispred,
   input  logic [IDW-1:0]             q_id1,
   input  logic [IDW-1:0]             q_id2,
   output logic                       q_rdy1,
   output logic                       q_rdy2,
   output logic [VAL_W-1:0]           q_val1,
   output logic [VAL_W-1:0]           q_val2,
   output logic [COMMIT_W-1:0]        cm_valid,
   output logic [COMMIT_W*IDW-1:0]    cm_id,
   output logic [COMMIT_W*RD_W-1:0]   cm_rd,
   output logic [COMMIT_W*VAL_W-1:0]  cm_val,
   output logic                       flush,
   output logic [31:0]                flush_pc
);

   localparam int CNT_W  = clog2(COMMIT_W + 1);
   localparam int LANE_W = (COMMIT_W > 1) ? clog2(COMMIT_W) : 1;

   logic [DEPTH-1:0] busy_q, done_q, misp_q;
   cls_e             cls_q [DEPTH];
   logic [RD_W-1:0]  rd_q  [DEPTH];
   logic [VAL_W-1:0] val_q [DEPTH];
   logic [IDW-1:0]   head_q, tail_q;
   logic [IDW:0]     count_q, count_nxt;
   logic             full_q, issue_ok;

   // The pc travels with the instruction but nothing downstream reads it here.
   logic unused_pc;
   assign unused_pc = ^issue_pc;

   logic [IDW-1:0]            lane_id [COMMIT_W];
   logic [COMMIT_W-1:0]       l_busy, l_done, l_misp, sel_valid;
   logic [COMMIT_W*CLS_W-1:0] l_cls;
   logic [CNT_W-1:0]          n_ret;
   logic                      sel_flush;
   logic [LANE_W-1:0]         flush_lane;

   always_comb begin
      for (int k = 0; k < COMMIT_W; k++) begin
         lane_id[k]               = head_q + IDW'(k);
         l_busy[k]                = busy_q[lane_id[k]];
         l_done[k]                = done_q[lane_id[k]];
         l_misp[k]                = misp_q[lane_id[k]];
         l_cls[k*CLS_W +: CLS_W]  = cls_q[lane_id[k]];
      end
   end

   rob_commit_sel #(
      .COMMIT_W (COMMIT_W),
      .CNT_W    (CNT_W),
      .LANE_W   (LANE_W)
   ) u_sel (
      .en         (rdy),
      .busy       (l_busy),
      .done       (l_done),
      .mispred    (l_misp),
      .cls        (l_cls),
      .valid      (sel_valid),
      .n_ret      (n_ret),
      .flush      (sel_flush),
      .flush_lane (flush_lane)
   );

   always_comb begin
      cm_valid = sel_valid;
      cm_id    = '0;
      cm_rd    = '0;
      cm_val   = '0;
      flush    = sel_flush;
      flush_pc = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         if (sel_valid[k]) begin
            cm_id[k*IDW +: IDW]     = lane_id[k];
            cm_val[k*VAL_W +: VAL_W] = val_q[lane_id[k]];
            if (cls_q[lane_id[k]] != CLS_STORE && cls_q[lane_id[k]] != CLS_BRANCH)
               cm_rd[k*RD_W +: RD_W] = rd_q[lane_id[k]];
            if (sel_flush && flush_lane == LANE_W'(k))
               flush_pc = val_q[lane_id[k]];
         end
      end
   end

   logic [IDW-1:0]   qid [2];
   logic             qr  [2];
   logic [VAL_W-1:0] qv  [2];

   assign qid[0] = q_id1;
   assign qid[1] = q_id2;

   // Stored value wins; otherwise the highest matching writeback channel.
   always_comb begin
      logic             hit;
      logic [VAL_W-1:0] byp;
      for (int i = 0; i < 2; i++) begin
         hit = 1'b0;
         byp = '0;
         for (int c = 0; c < NUM_WB; c++) begin
            if (wb_valid[c] && wb_id[c*IDW +: IDW] == qid[i]) begin
               hit = 1'b1;
               byp = wb_val[c*VAL_W +: VAL_W];
            end
         end
         qr[i] = busy_q[qid[i]] & (done_q[qid[i]] | hit);
         qv[i] = '0;
         if (busy_q[qid[i]]) begin
            if (done_q[qid[i]]) qv[i] = val_q[qid[i]];
            else if (hit)       qv[i] = byp;
         end
      end
   end

   assign q_rdy1 = qr[0];
   assign q_rdy2 = qr[1];
   assign q_val1 = qv[0];
   assign q_val2 = qv[1];

   assign issue_ok  = issue_valid & ~full_q;
   assign count_nxt = count_q + (IDW+1)'(issue_ok) - (IDW+1)'(n_ret);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         done_q  <= '0;
         misp_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            cls_q[i] <= CLS_ALU;
            rd_q[i]  <= '0;
            val_q[i] <= '0;
         end
      end else if (rdy) begin
         if (sel_flush) begin
            busy_q  <= '0;
            done_q  <= '0;
            misp_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
         end else begin
            for (int c = 0; c < NUM_WB; c++) begin
               if (wb_valid[c] && busy_q[wb_id[c*IDW +: IDW]]) begin
                  done_q[wb_id[c*IDW +: IDW]] <= 1'b1;
                  val_q[wb_id[c*IDW +: IDW]]  <= wb_val[c*VAL_W +: VAL_W];
                  misp_q[wb_id[c*IDW +: IDW]] <= wb_mispred[c];
               end
            end
            if (issue_ok) begin
               busy_q[tail_q] <= 1'b1;
               cls_q[tail_q]  <= cls_e'(issue_cls);
               rd_q[tail_q]   <= issue_rd;
               val_q[tail_q]  <= issue_val;
               done_q[tail_q] <= issue_done;
               misp_q[tail_q] <= 1'b0;
               tail_q         <= tail_q + 1'b1;
            end
            // Retire clears come last so they override a writeback to the same slot.
            for (int k = 0; k < COMMIT_W; k++) begin
               if (sel_valid[k]) begin
                  busy_q[lane_id[k]] <= 1'b0;
                  done_q[lane_id[k]] <= 1'b0;
               end
            end
            head_q  <= head_q + IDW'(n_ret);
            count_q <= count_nxt;
            full_q  <= (count_nxt == (IDW+1)'(DEPTH));
         end
      end
   end

   assign alloc_id = tail_q;
   assign head_id  = head_q;
   assign count    = count_q;
   assign full     = full_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Randomized bench for rob_multi_commit against a queue-based reference
// model, plus directed fill, bypass and mid-operation reset scenarios.
module tb_rob_multi_commit;

   localparam int D = 16;
   localparam int CW = 2;
   localparam int NW = 2;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        issue_valid, issue_done;
   logic [2:0]  issue_cls;
   logic [4:0]  issue_rd;
   logic [31:0] issue_pc, issue_val;
   logic [3:0]  alloc_id, head_id;
   logic        full;
   logic [4:0]  count;
   logic [1:0]  wb_valid, wb_mispred;
   logic [7:0]  wb_id;
   logic [63:0] wb_val;
   logic [3:0]  q_id1, q_id2;
   logic        q_rdy1, q_rdy2;
   logic [31:0] q_val1, q_val2;
   logic [1:0]  cm_valid;
   logic [7:0]  cm_id;
   logic [9:0]  cm_rd;
   logic [63:0] cm_val;
   logic        flush;
   logic [31:0] flush_pc;

   int n_checks = 0;
   int n_err = 0;

   typedef struct {
      int          id;
      int          cls;
      int          rd;
      logic [31:0] val;
      bit          done;
      bit          mispred;
   } ent_t;

   ent_t mq[$];
   int   mhead, mtail;

   always #5 clk = ~clk;

   rob_multi_commit #(.DEPTH(D), .COMMIT_W(CW), .NUM_WB(NW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .issue_valid(issue_valid), .issue_cls(issue_cls), .issue_rd(issue_rd),
      .issue_pc(issue_pc), .issue_val(issue_val), .issue_done(issue_done),
      .alloc_id(alloc_id), .full(full), .head_id(head_id), .count(count),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
      .wb_mispred(wb_mispred),
      .q_id1(q_id1), .q_id2(q_id2), .q_rdy1(q_rdy1), .q_rdy2(q_rdy2),
      .q_val1(q_val1), .q_val2(q_val2),
      .cm_valid(cm_valid), .cm_id(cm_id), .cm_rd(cm_rd), .cm_val(cm_val),
      .flush(flush), .flush_pc(flush_pc)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void lookup(input logic [3:0] id, output bit r,
                                  output logic [31:0] v);
      r = 0;
      v = '0;
      foreach (mq[i]) begin
         if (mq[i].id == int'(id)) begin
            if (mq[i].done) begin
               r = 1;
               v = mq[i].val;
            end else begin
               for (int c = 0; c < NW; c++) begin
                  if (wb_valid[c] && wb_id[c*4 +: 4] == id) begin
                     r = 1;
                     v = wb_val[c*32 +: 32];
                  end
               end
            end
         end
      end
   endfunction

   task automatic idle_inputs();
      rdy = 1;
      issue_valid = 0; issue_cls = 0; issue_rd = 0; issue_pc = 0;
      issue_val = 0; issue_done = 0;
      wb_valid = 0; wb_id = 0; wb_val = 0; wb_mispred = 0;
      q_id1 = 0; q_id2 = 0;
   endtask

   task automatic model_clear();
      mq.delete();
      mhead = 0;
      mtail = 0;
   endtask

   // Called just after a negedge with inputs already driven.
   task automatic step();
      int          nret;
      bit          mf, r, was_full;
      logic [31:0] mpc, v;
      nret = 0; mf = 0; mpc = 0;
      if (rdy) begin
         for (int k = 0; k < CW && k < mq.size(); k++) begin
            if (!mq[k].done) break;
            if (k > 0 && mq[k].cls == 2) break;
            nret++;
            if (mq[k].cls == 2) break;
            if (mq[k].cls == 3 && mq[k].mispred) begin
               mf = 1;
               mpc = mq[k].val;
               break;
            end
         end
      end
      #1;
      check("cm_valid", 64'(cm_valid), 64'((1 << nret) - 1));
      for (int k = 0; k < nret; k++) begin
         check("cm_id", 64'(cm_id[k*4 +: 4]), 64'(mq[k].id));
         check("cm_rd", 64'(cm_rd[k*5 +: 5]),
               (mq[k].cls == 2 || mq[k].cls == 3) ? 64'd0 : 64'(mq[k].rd));
         check("cm_val", 64'(cm_val[k*32 +: 32]), 64'(mq[k].val));
      end
      check("flush", 64'(flush), 64'(mf));
      if (mf) check("flush_pc", 64'(flush_pc), 64'(mpc));
      lookup(q_id1, r, v);
      check("q_rdy1", 64'(q_rdy1), 64'(r));
      if (r) check("q_val1", 64'(q_val1), 64'(v));
      lookup(q_id2, r, v);
      check("q_rdy2", 64'(q_rdy2), 64'(r));
      if (r) check("q_val2", 64'(q_val2), 64'(v));
      @(posedge clk);
      if (rdy) begin
         if (mf) begin
            model_clear();
         end else begin
            was_full = (mq.size() == D);
            repeat (nret) void'(mq.pop_front());
            mhead = (mhead + nret) % D;
            for (int c = 0; c < NW; c++) begin
               if (wb_valid[c]) begin
                  foreach (mq[i]) begin
                     if (mq[i].id == int'(wb_id[c*4 +: 4])) begin
                        mq[i].done = 1;
                        mq[i].val = wb_val[c*32 +: 32];
                        mq[i].mispred = wb_mispred[c];
                     end
                  end
               end
            end
            if (issue_valid && !was_full) begin
               mq.push_back('{id: mtail, cls: int'(issue_cls),
                              rd: int'(issue_rd), val: issue_val,
                              done: issue_done, mispred: 1'b0});
               mtail = (mtail + 1) % D;
            end
         end
      end
      #1;
      check("count", 64'(count), 64'(mq.size()));
      check("full", 64'(full), 64'(mq.size() == D));
      check("head_id", 64'(head_id), 64'(mhead));
      check("alloc_id", 64'(alloc_id), 64'(mtail));
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      int idx;
      rdy = ($urandom_range(0, 9) != 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_cls = 3'($urandom_range(0, 5));
      issue_rd = 5'($urandom);
      issue_pc = $urandom;
      issue_val = $urandom;
      issue_done = (issue_cls >= 3'd4);
      wb_valid = 0; wb_id = 0; wb_val = 0; wb_mispred = 0;
      for (int c = 0; c < NW; c++) begin
         if (mq.size() > 0 && $urandom_range(0, 9) < 6) begin
            idx = $urandom_range(0, mq.size() - 1);
            if (!mq[idx].done) begin
               wb_valid[c] = 1'b1;
               wb_id[c*4 +: 4] = 4'(mq[idx].id);
               wb_val[c*32 +: 32] = $urandom;
               wb_mispred[c] = (mq[idx].cls == 3) && ($urandom_range(0, 3) == 0);
            end
         end
      end
      q_id1 = 4'($urandom);
      q_id2 = 4'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
         q_id1 = 4'(mq[$urandom_range(0, mq.size() - 1)].id);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      idle_inputs();
      @(negedge clk);
      rst = 0;
      model_clear();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_full", 64'(full), 64'd0);
      check("rst_head", 64'(head_id), 64'd0);
      check("rst_alloc", 64'(alloc_id), 64'd0);
      check("rst_cm_valid", 64'(cm_valid), 64'd0);
      check("rst_flush", 64'(flush), 64'd0);
      rst = 0;
      model_clear();
      @(negedge clk);

      // Fill with 17 ALU issues; the last is dropped.
      for (int i = 0; i < 17; i++) begin
         issue_valid = 1;
         issue_cls = 3'd0;
         issue_rd = 5'(i + 1);
         issue_val = 32'(i);
         issue_done = 0;
         step();
         if (i == 15) begin
            check("fill_full", 64'(full), 64'd1);
            check("fill_count", 64'(count), 64'd16);
         end
      end
      check("fill_alloc_wrap", 64'(alloc_id), 64'd0);
      check("fill_still_16", 64'(count), 64'd16);

      // Same-cycle writeback bypass on channel 1.
      issue_valid = 0;
      q_id1 = 4'd3;
      wb_valid = 2'b10;
      wb_id = {4'd3, 4'd0};
      wb_val = {32'h0000ABCD, 32'h0};
      #1;
      check("byp_rdy", 64'(q_rdy1), 64'd1);
      check("byp_val", 64'(q_val1), 64'h0000ABCD);
      step();

      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         step();
      end

      // Asynchronous reset between edges with five entries live.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         idle_inputs();
         issue_valid = 1;
         issue_rd = 5'(i + 1);
         step();
      end
      check("mid_count_5", 64'(count), 64'd5);
      idle_inputs();
      #2;
      rst = 1;
      #1;
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_full", 64'(full), 64'd0);
      check("mid_rst_head", 64'(head_id), 64'd0);
      check("mid_rst_alloc", 64'(alloc_id), 64'd0);
      check("mid_rst_cm", 64'(cm_valid), 64'd0);
      @(negedge clk);
      rst = 0;
      model_clear();

      for (int n = 0; n < 500; n++) begin
         rand_inputs();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
